// File: rtl/ysyx_23060124_pkg.sv
// Shared definitions for the ysyx_23060124 write-back path: FSM encoding and
// the RV32I load funct3 codes.
package ysyx_23060124_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } wbu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060124_load_ext.sv
// Combinational load extractor: picks the byte/half/word addressed by addr
// out of an aligned 32-bit word and sign- or zero-extends it.
module ysyx_23060124_load_ext
  import ysyx_23060124_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfwords ignore addr[0]; misaligned halves are the LSU's problem.
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
      LW:      data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_wbu.sv
// Write-back unit: takes retired results from the EXU, waits for LSU data on
// loads, drives the register-file write port and counts retired instructions.
module ysyx_23060124_wbu
  import ysyx_23060124_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_exu_valid,
  output logic            o_exu_ready,
  input  logic [RA_W-1:0] i_exu_rd,
  input  logic            i_exu_wen,
  input  logic [XLEN-1:0] i_exu_res,
  input  logic            i_exu_is_load,
  input  logic [2:0]      i_exu_funct3,
  input  logic            i_lsu_rvalid,
  input  logic [XLEN-1:0] i_lsu_rdata,
  output logic            o_rf_wen,
  output logic [RA_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_busy,
  output logic [RA_W-1:0] o_busy_rd,
  output logic            o_commit,
  output logic [XLEN-1:0] o_instret,
  output logic [1:0]      o_dbg_state
);

  wbu_state_t      state_q, state_d;
  logic [RA_W-1:0] rd_q;
  logic            wen_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] instret_q;
  logic [XLEN-1:0] load_word;
  logic            accept;
  logic            commit;
  logic            rd_live;

  // Handshake: a transfer happens on a cycle where i_exu_valid and o_exu_ready
  // are both high; ready depends only on reset and registered state, and the
  // EXU must hold its payload stable while valid is high and ready is low.
  assign o_exu_ready = ~i_rst & (state_q != WAIT_LOAD);
  assign accept      = i_exu_valid & o_exu_ready;

  ysyx_23060124_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .funct3(funct3_q),
    .addr  (addr_q),
    .rdata (i_lsu_rdata),
    .data  (load_word)
  );

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = i_exu_is_load ? WAIT_LOAD : WRITE;
      end
      WAIT_LOAD: begin
        if (i_lsu_rvalid) state_d = WRITE;
      end
      WRITE: begin
        commit = 1'b1;
        if (accept) state_d = i_exu_is_load ? WAIT_LOAD : WRITE;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 2'b00;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q     <= i_exu_rd;
        wen_q    <= i_exu_wen;
        funct3_q <= i_exu_funct3;
        addr_q   <= i_exu_res[1:0];
        data_q   <= i_exu_res;
      end else if (state_q == WAIT_LOAD && i_lsu_rvalid) begin
        data_q <= load_word;
      end
      if (commit) instret_q <= instret_q + XLEN'(1);
    end
  end

  // x0 is hardwired, so it is never reported as a pending or written target.
  assign rd_live     = wen_q & (rd_q != '0);
  assign o_rf_wen    = commit & rd_live;
  assign o_rf_waddr  = rd_q;
  assign o_rf_wdata  = data_q;
  assign o_busy      = (state_q != IDLE) & rd_live;
  assign o_busy_rd   = rd_q;
  assign o_commit    = commit;
  assign o_instret   = instret_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Self-checking bench for ysyx_23060124_wbu: scenario tasks plus a
// scoreboard that matches every commit against an expected write queue.
module tb_ysyx_23060124_wbu;
  import ysyx_23060124_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int EW   = 1 + RA_W + XLEN;
  localparam int NLD  = 11;

  localparam logic [2:0]  LD_F3  [NLD] = '{LB, LBU, LH, LHU, LW, LB, LBU, LH, LHU,
                                           3'b011, 3'b110};
  localparam logic [31:0] LD_ADR [NLD] = '{32'h1000, 32'h1001, 32'h1002, 32'h1000,
                                           32'h1000, 32'h1003, 32'h1002, 32'h1001,
                                           32'h1003, 32'h1002, 32'h1001};
  localparam logic [31:0] LD_EXP [NLD] = '{32'hFFFFFFA5, 32'h000000F0, 32'hFFFF8077,
                                           32'h0000F0A5, 32'h8077F0A5, 32'hFFFFFF80,
                                           32'h00000077, 32'hFFFFF0A5, 32'h00008077,
                                           32'h8077F0A5, 32'h8077F0A5};

  // clock/reset
  logic clk   = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;

  logic            i_exu_valid = 1'b0;
  logic            o_exu_ready;
  logic [RA_W-1:0] i_exu_rd = '0;
  logic            i_exu_wen = 1'b0;
  logic [XLEN-1:0] i_exu_res = '0;
  logic            i_exu_is_load = 1'b0;
  logic [2:0]      i_exu_funct3 = 3'b000;
  logic            i_lsu_rvalid = 1'b0;
  logic [XLEN-1:0] i_lsu_rdata = '0;
  logic            o_rf_wen;
  logic [RA_W-1:0] o_rf_waddr;
  logic [XLEN-1:0] o_rf_wdata;
  logic            o_busy;
  logic [RA_W-1:0] o_busy_rd;
  logic            o_commit;
  logic [XLEN-1:0] o_instret;
  logic [1:0]      o_dbg_state;

  ysyx_23060124_wbu #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_exu_valid  (i_exu_valid),
    .o_exu_ready  (o_exu_ready),
    .i_exu_rd     (i_exu_rd),
    .i_exu_wen    (i_exu_wen),
    .i_exu_res    (i_exu_res),
    .i_exu_is_load(i_exu_is_load),
    .i_exu_funct3 (i_exu_funct3),
    .i_lsu_rvalid (i_lsu_rvalid),
    .i_lsu_rdata  (i_lsu_rdata),
    .o_rf_wen     (o_rf_wen),
    .o_rf_waddr   (o_rf_waddr),
    .o_rf_wdata   (o_rf_wdata),
    .o_busy       (o_busy),
    .o_busy_rd    (o_busy_rd),
    .o_commit     (o_commit),
    .o_instret    (o_instret),
    .o_dbg_state  (o_dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v, got_v;
  logic [31:0] model_instret = '0;

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (a * 8));
    h = 16'(w >> (a[1] * 16));
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // scoreboard: every commit pops one expected {wen, waddr, wdata}
  always @(negedge clk) begin
    if (o_commit === 1'b1) begin
      got_v = {o_rf_wen, o_rf_waddr, o_rf_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_commit got wen=%b waddr=%0d wdata=%h, expected no commit",
                 o_rf_wen, o_rf_waddr, o_rf_wdata);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL sb_write got wen=%b waddr=%0d wdata=%h, expected wen=%b waddr=%0d wdata=%h",
                   got_v[EW-1], got_v[XLEN+:RA_W], got_v[XLEN-1:0],
                   exp_v[EW-1], exp_v[XLEN+:RA_W], exp_v[XLEN-1:0]);
        end
      end
      checks++;
      if (o_instret !== model_instret) begin
        errors++;
        $display("FAIL sb_instret got=%h expected=%h", o_instret, model_instret);
      end
      model_instret = model_instret + 32'd1;
    end else begin
      checks++;
      if (o_rf_wen !== 1'b0) begin
        errors++;
        $display("FAIL sb_wen_without_commit got=%b expected=0", o_rf_wen);
      end
    end
  end

  // driver tasks; each is entered just after a falling edge
  task automatic idle_cycles(input int n);
    i_exu_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [RA_W-1:0] rd, input logic wen, input logic [XLEN-1:0] res,
                       input logic is_load, input logic [2:0] f3, input logic [XLEN-1:0] rdata,
                       input int lat, input logic [XLEN-1:0] exp_data);
    logic live;
    live = wen & (rd != '0);
    checks++;
    if (o_exu_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got=%b expected=1", o_exu_ready);
    end
    i_exu_valid = 1'b1; i_exu_rd = rd; i_exu_wen = wen; i_exu_res = res;
    i_exu_is_load = is_load; i_exu_funct3 = f3;
    exp_q.push_back({live, rd, exp_data});
    @(negedge clk);
    if (is_load) begin
      i_exu_valid = 1'b0;
      for (int c = 1; c < lat; c++) begin
        checks++;
        if (o_busy !== live || o_busy_rd !== rd || o_exu_ready !== 1'b0) begin
          errors++;
          $display("FAIL load_wait got busy=%b busy_rd=%0d ready=%b, expected busy=%b busy_rd=%0d ready=0",
                   o_busy, o_busy_rd, o_exu_ready, live, rd);
        end
        @(negedge clk);
      end
      i_lsu_rvalid = 1'b1; i_lsu_rdata = rdata;
      @(negedge clk);
      i_lsu_rvalid = 1'b0; i_lsu_rdata = $urandom();
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_exu_valid = 1'b1; i_exu_rd = 5'd3; i_exu_wen = 1'b1; i_exu_res = 32'hDEAD;
    repeat (3) @(negedge clk);
    checks++;
    if (o_exu_ready !== 1'b0 || o_rf_wen !== 1'b0 || o_commit !== 1'b0 || o_busy !== 1'b0 ||
        o_busy_rd !== '0 || o_rf_waddr !== '0 || o_rf_wdata !== '0 || o_instret !== '0 ||
        o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b wen=%b commit=%b busy=%b busy_rd=%0d waddr=%0d wdata=%h instret=%h state=%0d, expected all 0",
               o_exu_ready, o_rf_wen, o_commit, o_busy, o_busy_rd, o_rf_waddr, o_rf_wdata,
               o_instret, o_dbg_state);
    end
    i_exu_valid = 1'b0;
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_exu_ready !== 1'b1 || o_instret !== '0) begin
      errors++;
      $display("FAIL reset_release got ready=%b instret=%h expected ready=1 instret=0",
               o_exu_ready, o_instret);
    end
  endtask

  task automatic test_alu_stream();
    issue(5'd1, 1'b1, 32'h11, 1'b0, LW, '0, 1, 32'h11);
    for (int k = 2; k <= 3; k++) begin
      checks++;
      if (o_commit !== 1'b1 || o_exu_ready !== 1'b1) begin
        errors++;
        $display("FAIL alu_stream_cycle%0d got commit=%b ready=%b expected 1 1", k - 1, o_commit, o_exu_ready);
      end
      issue(RA_W'(k), 1'b1, 32'(k * 32'h11), 1'b0, LW, '0, 1, 32'(k * 32'h11));
    end
    checks++;
    if (o_commit !== 1'b1 || o_rf_waddr !== 5'd3) begin
      errors++;
      $display("FAIL alu_stream_last got commit=%b waddr=%0d expected 1 3", o_commit, o_rf_waddr);
    end
    idle_cycles(1);
    checks++;
    if (o_instret !== 32'd3 || o_commit !== 1'b0) begin
      errors++;
      $display("FAIL alu_stream_instret got instret=%0d commit=%b expected 3 0", o_instret, o_commit);
    end
  endtask

  task automatic test_rd0_nowen();
    issue(5'd0, 1'b1, 32'hFFFF, 1'b0, LW, '0, 1, 32'hFFFF);
    checks++;
    if (o_rf_wen !== 1'b0 || o_commit !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd0 got wen=%b commit=%b busy=%b expected 0 1 0", o_rf_wen, o_commit, o_busy);
    end
    issue(5'd7, 1'b0, 32'h1234, 1'b1, LW, 32'h5555AAAA, 2, 32'h5555AAAA);
    checks++;
    if (o_rf_wen !== 1'b0 || o_commit !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL nowen_load got wen=%b commit=%b busy=%b expected 0 1 0", o_rf_wen, o_commit, o_busy);
    end
    idle_cycles(1);
  endtask

  task automatic test_loads();
    for (int i = 0; i < NLD; i++)
      issue(RA_W'(10 + i), 1'b1, LD_ADR[i], 1'b1, LD_F3[i], 32'h8077F0A5, 1 + (i % 3), LD_EXP[i]);
    idle_cycles(1);
  endtask

  task automatic test_load_stall();
    i_exu_valid = 1'b1; i_exu_rd = 5'd5; i_exu_wen = 1'b1; i_exu_res = 32'h2000;
    i_exu_is_load = 1'b1; i_exu_funct3 = LW;
    exp_q.push_back({1'b1, 5'd5, 32'hCAFEF00D});
    @(negedge clk);
    // a younger ALU op waits with valid held through the stall
    i_exu_is_load = 1'b0; i_exu_rd = 5'd6; i_exu_res = 32'h66;
    exp_q.push_back({1'b1, 5'd6, 32'h66});
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_busy !== 1'b1 || o_busy_rd !== 5'd5 || o_exu_ready !== 1'b0 || o_commit !== 1'b0) begin
        errors++;
        $display("FAIL stall_c%0d got busy=%b busy_rd=%0d ready=%b commit=%b expected 1 5 0 0",
                 c, o_busy, o_busy_rd, o_exu_ready, o_commit);
      end
      if (c == 3) begin
        i_lsu_rvalid = 1'b1; i_lsu_rdata = 32'hCAFEF00D;
      end
      @(negedge clk);
    end
    i_lsu_rvalid = 1'b0;
    checks++;
    if (o_commit !== 1'b1 || o_rf_waddr !== 5'd5 || o_exu_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_write got commit=%b waddr=%0d ready=%b expected 1 5 1", o_commit, o_rf_waddr, o_exu_ready);
    end
    @(negedge clk);
    idle_cycles(1);
    // stray response while idle
    i_lsu_rvalid = 1'b1; i_lsu_rdata = 32'h12345678;
    @(negedge clk);
    i_lsu_rvalid = 1'b0;
    checks++;
    if (o_commit !== 1'b0 || o_rf_wen !== 1'b0 || o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL stray_rvalid got commit=%b wen=%b state=%0d expected 0 0 0", o_commit, o_rf_wen, o_dbg_state);
    end
    // response coinciding with the accept must be ignored
    i_exu_valid = 1'b1; i_exu_rd = 5'd8; i_exu_wen = 1'b1; i_exu_res = 32'h3003;
    i_exu_is_load = 1'b1; i_exu_funct3 = LBU;
    i_lsu_rvalid = 1'b1; i_lsu_rdata = 32'h11223344;
    exp_q.push_back({1'b1, 5'd8, 32'h000000AA});
    @(negedge clk);
    i_exu_valid = 1'b0; i_lsu_rvalid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_commit !== 1'b0 || o_exu_ready !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_rvalid got busy=%b commit=%b ready=%b expected 1 0 0", o_busy, o_commit, o_exu_ready);
    end
    @(negedge clk);
    i_lsu_rvalid = 1'b1; i_lsu_rdata = 32'hAABBCCDD;
    @(negedge clk);
    i_lsu_rvalid = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_load();
    i_exu_valid = 1'b1; i_exu_rd = 5'd9; i_exu_wen = 1'b1; i_exu_res = 32'h4000;
    i_exu_is_load = 1'b1; i_exu_funct3 = LW;
    @(negedge clk);
    i_exu_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_busy_rd !== 5'd9) begin
      errors++;
      $display("FAIL midload_busy got busy=%b busy_rd=%0d expected 1 9", o_busy, o_busy_rd);
    end
    #2;
    i_rst = 1'b1;
    model_instret = '0;
    i_lsu_rvalid = 1'b1; i_lsu_rdata = 32'h99999999;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_commit !== 1'b0 || o_exu_ready !== 1'b0 || o_instret !== '0 ||
        o_busy_rd !== '0) begin
      errors++;
      $display("FAIL midload_reset got busy=%b commit=%b ready=%b instret=%h busy_rd=%0d expected all 0",
               o_busy, o_commit, o_exu_ready, o_instret, o_busy_rd);
    end
    @(negedge clk);
    i_rst = 1'b0; i_lsu_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_commit !== 1'b0 || o_instret !== '0 || o_exu_ready !== 1'b1) begin
      errors++;
      $display("FAIL midload_release got commit=%b instret=%h ready=%b expected 0 0 1", o_commit, o_instret, o_exu_ready);
    end
    issue(5'd4, 1'b1, 32'h44, 1'b0, LW, '0, 1, 32'h44);
    idle_cycles(1);
    checks++;
    if (o_instret !== 32'd1) begin
      errors++;
      $display("FAIL midload_next got instret=%0d expected 1", o_instret);
    end
  endtask

  task automatic test_wrap();
    force dut.instret_q = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    model_instret = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (o_instret !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL wrap_preset got=%h expected=ffffffff", o_instret);
    end
    issue(5'd3, 1'b1, 32'h77, 1'b0, LW, '0, 1, 32'h77);
    idle_cycles(1);
    checks++;
    if (o_instret !== 32'h0) begin
      errors++;
      $display("FAIL wrap_result got=%h expected=00000000", o_instret);
    end
  endtask

  task automatic test_back_to_back();
    logic [RA_W-1:0] rd;
    logic            wen, ld;
    logic [2:0]      f3;
    logic [31:0]     res, rdata;
    for (int i = 0; i < 40; i++) begin
      rd    = RA_W'($urandom_range(0, 31));
      wen   = 1'($urandom_range(0, 3) != 0);
      ld    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      res   = $urandom();
      rdata = $urandom();
      issue(rd, wen, res, ld, f3, rdata, $urandom_range(1, 3),
            ld ? model_ext(f3, res[1:0], rdata) : res);
    end
    idle_cycles(2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired with %0d writes still expected", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_stream();
    test_rd0_nowen();
    test_loads();
    test_load_stall();
    test_reset_mid_load();
    test_wrap();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d writes outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
